// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - Host write port and transmitter launch port of uart_tx_feeder
interface uart_tx_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_en;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic [DATA_WIDTH-1:0]  P_DATA;
  logic                   Data_valid;
  logic                   busy;

  modport master (
    output wr_data, wr_en, busy,
    input  full, empty, level, overflow, P_DATA, Data_valid
  );

  modport slave (
    input  wr_data, wr_en, busy,
    output full, empty, level, overflow, P_DATA, Data_valid
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - Byte FIFO and one-byte-per-frame launch FSM ahead of the UART transmitter
// Inter-frame idle gap is compiled in when UART_TX_FEEDER_GAP_EN is defined.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic            CLK,
  input  logic            RST,
  uart_tx_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_HI,
    WAIT_LO
`ifdef UART_TX_FEEDER_GAP_EN
    , GAP
`endif
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  overflow_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  state_t                state;
  state_t                state_nxt;
  logic                  push;
  logic                  pop;

  // full is the registered flag, so a write while full is dropped even if a pop frees a slot this cycle
  assign push = bus.wr_en && !full_q;

  always_comb begin
    level_nxt = level_q;
    if (push && !pop) begin
      level_nxt = level_q + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level_q - LW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level_q <= level_nxt;
      full_q  <= (level_nxt == LW'(DEPTH));
      empty_q <= (level_nxt == '0);
      if (bus.wr_en && full_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

`ifdef UART_TX_FEEDER_GAP_EN
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge CLK) begin
    if (RST || (state != GAP)) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end
`else
  // GAP_CYCLES only shapes the build that includes the gap state
  logic [31:0] unused_gap_cycles;
  assign unused_gap_cycles = GAP_CYCLES;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_q && !bus.busy) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH:  state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (bus.busy) begin
          state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!bus.busy) begin
`ifdef UART_TX_FEEDER_GAP_EN
          state_nxt = GAP;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef UART_TX_FEEDER_GAP_EN
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // The strobe is the registered pop, so it is high exactly during the LAUNCH cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= pop;
      if (pop) begin
        p_data_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.level      = level_q;
  assign bus.overflow   = overflow_q;
  assign bus.P_DATA     = p_data_q;
  assign bus.Data_valid = data_valid_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - Randomized self-checking bench for uart_tx_feeder against a queue model
module tb_uart_tx_feeder;
  localparam int DW         = 8;
  localparam int DEPTH      = 8;
  localparam int GAP_CYCLES = 4;
  localparam int TX_HOLD    = 12;
`ifdef UART_TX_FEEDER_GAP_EN
  localparam int EXP_GAP = 2 + GAP_CYCLES;
`else
  localparam int EXP_GAP = 2;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_tx_feeder_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned tick_n  = 0;

  logic [DW-1:0] q[$];
  int unsigned   mdl_cnt   = 0;
  logic          mdl_ovf   = 1'b0;
  logic [DW-1:0] mdl_pdata = '0;

  logic        prev_dv        = 1'b0;
  int unsigned dv_count       = 0;
  int unsigned last_dv_tick   = 0;
  int unsigned last_wr_tick   = 0;
  int unsigned last_fall_tick = 0;

  logic ext_busy   = 1'b0;
  logic tx_busy    = 1'b0;
  logic tx_pending = 1'b0;
  int   tx_left    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (tick %0d)", tag, obs, exp, tick_n);
    end
  endtask

  // One clock: apply the model for the edge, compare all outputs, then run the transmitter model
  task automatic tick();
    logic          acc;
    logic          ovf_hit;
    logic          rst_now;
    logic          dv;
    logic [DW-1:0] wdata;
    int unsigned   pre;
    acc     = bus.wr_en && (mdl_cnt < DEPTH);
    ovf_hit = bus.wr_en && (mdl_cnt == DEPTH);
    rst_now = RST;
    wdata   = bus.wr_data;
    pre     = q.size();
    @(posedge CLK);
    #1;
    tick_n++;
    dv = bus.Data_valid;
    if (rst_now) begin
      q.delete();
      mdl_ovf   = 1'b0;
      mdl_pdata = '0;
      check("dv_in_reset", dv, 1'b0);
    end else begin
      if (acc) begin
        q.push_back(wdata);
        last_wr_tick = tick_n;
      end
      if (ovf_hit) mdl_ovf = 1'b1;
      if (dv) begin
        check("pop_nonempty", pre > 0, 1'b1);
        if (pre > 0) mdl_pdata = q.pop_front();
        dv_count++;
        last_dv_tick = tick_n;
      end
    end
    mdl_cnt = q.size();
    check("dv_single", dv && prev_dv, 1'b0);
    prev_dv = dv;
    check("level", bus.level, mdl_cnt);
    check("full", bus.full, mdl_cnt == DEPTH);
    check("empty", bus.empty, mdl_cnt == 0);
    check("overflow", bus.overflow, mdl_ovf);
    check("p_data", bus.P_DATA, mdl_pdata);
    if (tx_pending) begin
      tx_busy    = 1'b1;
      tx_left    = TX_HOLD;
      tx_pending = 1'b0;
    end else if (tx_busy) begin
      tx_left--;
      if (tx_left == 0) begin
        tx_busy        = 1'b0;
        last_fall_tick = tick_n;
      end
    end
    if (dv) tx_pending = 1'b1;
    bus.busy = tx_busy | ext_busy;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_dv(input string tag, input int unsigned target, input int budget);
    int k = 0;
    while (dv_count < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, dv_count >= target, 1'b1);
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || tx_busy || tx_pending || prev_dv) && k < 2000) begin
      tick();
      k++;
    end
    check("drain_timeout", k < 2000, 1'b1);
    run(GAP_CYCLES + 4);
  endtask

  initial begin
    int unsigned dv0;
    int unsigned t0;
    int          written;
    int          guard;
    logic [DW-1:0] first;

    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.busy    = 1'b0;
    RST = 1'b1;
    run(3);
    RST = 1'b0;
    run(2);

    // single byte: strobe once, one cycle after the accepting edge
    dv0 = dv_count;
    wr(8'hA5);
    t0 = last_wr_tick;
    check("a5_accept", t0, tick_n);
    wait_dv("a5_dv_timeout", dv0 + 1, 20);
    check("a5_latency", last_dv_tick - t0, 1);
    check("a5_pdata", bus.P_DATA, 8'hA5);
    drain();
    check("a5_once", dv_count - dv0, 1);

    // burst into a blocked transmitter, overflow, then in-order launch
    ext_busy = 1'b1;
    bus.busy = 1'b1;
    dv0 = dv_count;
    for (int i = 1; i <= 8; i++) wr(DW'(i));
    check("burst_full", bus.full, 1'b1);
    wr(8'hFF);
    check("burst_ovf", bus.overflow, 1'b1);
    check("burst_level", bus.level, DEPTH);
    run(10);
    check("hold_no_dv", dv_count - dv0, 0);
    ext_busy = 1'b0;
    bus.busy = tx_busy;
    drain();
    check("burst_frames", dv_count - dv0, 8);
    check("ovf_sticky", bus.overflow, 1'b1);

    // three queued behind external busy; release coincides with a write
    ext_busy = 1'b1;
    bus.busy = 1'b1;
    dv0 = dv_count;
    wr(8'h31);
    wr(8'h32);
    wr(8'h33);
    run(6);
    check("hold3_no_dv", dv_count - dv0, 0);
    ext_busy = 1'b0;
    bus.busy = tx_busy;
    wr(8'h34);
    check("lvl_same", bus.level, 3);
    check("resume_first", bus.P_DATA, 8'h31);
    drain();

    // pointer wrap twice with order preserved
    written = 0;
    guard   = 0;
    while (written < 20 && guard < 3000) begin
      if (mdl_cnt < DEPTH) begin
        wr(DW'($urandom));
        written++;
      end else begin
        tick();
      end
      guard++;
    end
    check("wrap_writes", written, 20);
    drain();

    // frame-to-frame spacing after busy falls
    dv0 = dv_count;
    wr(8'h5A);
    wr(8'hC3);
    wait_dv("gap_dv_timeout", dv0 + 2, 200);
    check("gap_latency", last_dv_tick - last_fall_tick, EXP_GAP);
    drain();

    // reset in WAIT_LO with four bytes queued
    for (int i = 0; i < 5; i++) wr(DW'(8'h90 + i));
    run(4);
    check("pre_rst_level", bus.level, 4);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_level", bus.level, 0);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_pdata", bus.P_DATA, 0);
    check("rst_ovf", bus.overflow, 1'b0);
    dv0 = dv_count;
    run(40);
    check("rst_no_dv", dv_count - dv0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.wr_en   = ($urandom_range(0, 15) < 2);
      bus.wr_data = DW'($urandom);
      tick();
    end
    bus.wr_en = 1'b0;
    drain();
    check("final_level", bus.level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
